// File: rtl/sc_fir_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sc_fir_pkg
// Shared definitions for the stochastic-computing FIR sequencer and the
// hardware-weighted adder (HWA) it drives.
//   TAPS            delay-line depth, matches the HWA `in` array
//   sc_ctrl_state_t sequencer FSM states
//   sign_b          per-tap sign flags consumed by the HWA (bit k set marks
//                   tap k as negative-weight); the sequencer only forwards taps
//   lfsr_mask()     Fibonacci feedback mask for a maximal-length LFSR of
//                   width n (4..16)
// ---------------------------------------------------------------------------
package sc_fir_pkg;

  localparam int TAPS = 39;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_OUT
  } sc_ctrl_state_t;

  localparam logic [TAPS-1:0] sign_b = '0;

  // Bit i of the mask selects register bit i into the XOR feedback. The
  // register shifts toward the MSB and the feedback enters bit 0.
  // N=8 corresponds to x^8+x^6+x^5+x^4+1.
  function automatic logic [15:0] lfsr_mask(input int n);
    case (n)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h00B8;
    endcase
  endfunction

endpackage

// File: rtl/sc_fir_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// sc_fir_seq_ctrl_if
// Bundles the sample input handshake, the HWA drive/return signals and the
// result handshake of the FIR sequencer.
//   master : the sequencer (sc_fir_seq_ctrl)
//   slave  : the environment (sample source, HWA, result sink)
// Signals:
//   in_valid/in_ready/in_data  sample handshake
//   taps                       delay line, taps[0] newest, to HWA `in`
//   start                      one-cycle HWA clear pulse
//   sel_bits                   window counter to HWA
//   R_y                        LFSR random number to HWA
//   hwa_out/hwa_done           HWA running count and terminal flag
//   y_valid/y_ready/y_data     result handshake
//   err                        sticky done-mismatch flag
// ---------------------------------------------------------------------------
interface sc_fir_seq_ctrl_if
  import sc_fir_pkg::*;
#(
  parameter int N    = 8,
  parameter int TAPS = sc_fir_pkg::TAPS
);

  logic                      in_valid;
  logic                      in_ready;
  logic [N-1:0]              in_data;
  logic [TAPS-1:0][N-1:0]    taps;
  logic                      start;
  logic [N-1:0]              sel_bits;
  logic [N-1:0]              R_y;
  logic [N-1:0]              hwa_out;
  logic                      hwa_done;
  logic                      y_valid;
  logic                      y_ready;
  logic [N-1:0]              y_data;
  logic                      err;

  modport master (
    input  in_valid, in_data, hwa_out, hwa_done, y_ready,
    output in_ready, taps, start, sel_bits, R_y, y_valid, y_data, err
  );

  modport slave (
    output in_valid, in_data, hwa_out, hwa_done, y_ready,
    input  in_ready, taps, start, sel_bits, R_y, y_valid, y_data, err
  );

endinterface

// File: rtl/sc_fir_seq_ctrl_lfsr.sv
// ---------------------------------------------------------------------------
// sc_lfsr
// Maximal-length Fibonacci LFSR supplying the comparison number R_y to the
// HWA. Advances only while `en` is high. SEED must be non-zero, otherwise
// the register locks at zero.
// Ports:
//   clock    clock
//   reset_n  asynchronous active-low reset, loads SEED
//   en       advance one step this cycle
//   q        current LFSR value
// ---------------------------------------------------------------------------
module sc_lfsr
  import sc_fir_pkg::*;
#(
  parameter int           N    = 8,
  parameter logic [N-1:0] SEED = N'(1)
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         en,
  output logic [N-1:0] q
);

  localparam logic [N-1:0] MASK = N'(lfsr_mask(N));

  logic [N-1:0] r_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= SEED;
    end else if (en) begin
      r_q <= {r_q[N-2:0], ^(r_q & MASK)};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/sc_fir_seq_ctrl.sv
// ---------------------------------------------------------------------------
// sc_fir_seq_ctrl
// Upstream sequencer for the stochastic-computing FIR HWA. Shifts each
// accepted sample into a TAPS-deep delay line, pulses `start`, then walks
// one 2^N-cycle bit-stream window (sel_bits 1..2^N-1) while advancing the
// LFSR. The HWA count is captured when `hwa_done` fires (or when the window
// runs out) and offered on the y handshake. No new sample is taken until the
// result is consumed.
// Ports:
//   clock    clock
//   reset_n  asynchronous active-low reset
//   bus      sc_fir_seq_ctrl_if.master (handshakes + HWA signals)
// Latency from the accept edge (cycle 0): start in cycle 1, RUN in cycles
// 2..2^N, y_valid from cycle 2^N+1.
// ---------------------------------------------------------------------------
module sc_fir_seq_ctrl
  import sc_fir_pkg::*;
#(
  parameter int           N    = 8,
  parameter int           TAPS = sc_fir_pkg::TAPS,
  parameter logic [N-1:0] SEED = N'(1)
) (
  input  logic               clock,
  input  logic               reset_n,
  sc_fir_seq_ctrl_if.master  bus
);

  localparam logic [N-1:0] SEL_LAST = '1;

  sc_ctrl_state_t           r_state;
  logic                     r_in_ready;
  logic                     r_start;
  logic                     r_y_valid;
  logic                     r_err;
  logic [N-1:0]             r_sel;
  logic [N-1:0]             r_y_data;
  logic [TAPS-1:0][N-1:0]   r_taps;

  logic                     w_lfsr_en;
  logic                     w_last;
  logic [N-1:0]             w_r_y;

  // The LFSR steps on the START cycle and every RUN cycle and holds
  // otherwise, so R_y is frozen while idle or waiting on the consumer.
  assign w_lfsr_en = (r_state == ST_START) || (r_state == ST_RUN);
  assign w_last    = (r_sel == SEL_LAST);

  sc_lfsr #(
    .N    (N),
    .SEED (SEED)
  ) u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (w_lfsr_en),
    .q       (w_r_y)
  );

  // NOTE: the delay line is reset like any other register: an aborted window
  // must leave no stale samples feeding the HWA after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b1;
      r_start    <= 1'b0;
      r_y_valid  <= 1'b0;
      r_err      <= 1'b0;
      r_sel      <= '0;
      r_y_data   <= '0;
      r_taps     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_taps     <= {r_taps[TAPS-2:0], bus.in_data};
            r_in_ready <= 1'b0;
            r_start    <= 1'b1;
            r_state    <= ST_START;
          end
        end

        ST_START: begin
          r_start <= 1'b0;
          r_sel   <= N'(1);
          r_state <= ST_RUN;
        end

        ST_RUN: begin
          if (bus.hwa_done || w_last) begin
            // Either edge of the window ends it; a done that does not line
            // up with the last counter value is flagged but still captured.
            r_y_data  <= bus.hwa_out;
            r_sel     <= '0;
            r_y_valid <= 1'b1;
            r_err     <= r_err | (bus.hwa_done ^ w_last);
            r_state   <= ST_OUT;
          end else begin
            r_sel <= r_sel + N'(1);
          end
        end

        ST_OUT: begin
          if (bus.y_ready) begin
            r_y_valid  <= 1'b0;
            r_in_ready <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b1;
          r_start    <= 1'b0;
          r_y_valid  <= 1'b0;
          r_sel      <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.taps     = r_taps;
  assign bus.start    = r_start;
  assign bus.sel_bits = r_sel;
  assign bus.R_y      = w_r_y;
  assign bus.y_valid  = r_y_valid;
  assign bus.y_data   = r_y_data;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_sc_fir_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sc_fir_seq_ctrl
// Directed bench for sc_fir_seq_ctrl. u_dut4 (N=4) carries the latency,
// LFSR, backpressure, done-mismatch and reset steps against a small HWA
// model (count += taps[0] >= R_y, cleared on start/done). u_dut8 (N=8)
// carries the 40-sample delay-line step.
// ---------------------------------------------------------------------------
module tb_sc_fir_seq_ctrl;
  import sc_fir_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   done_mode;      // 0: done at sel 15, 1: never, 2: early at sel 5
  logic [3:0]  cnt4;
  logic [15:0] seen;
  logic [3:0]  lfsr_exp [15];

  sc_fir_seq_ctrl_if #(.N(4), .TAPS(TAPS)) b4 ();
  sc_fir_seq_ctrl_if #(.N(8), .TAPS(TAPS)) b8 ();

  sc_fir_seq_ctrl #(.N(4), .TAPS(TAPS), .SEED(4'd1)) u_dut4 (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (b4.master)
  );

  sc_fir_seq_ctrl #(.N(8), .TAPS(TAPS), .SEED(8'd1)) u_dut8 (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (b8.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // HWA model for the N=4 instance
  assign b4.hwa_done = (done_mode == 0) ? (b4.sel_bits == 4'hF) :
                       (done_mode == 2) ? (b4.sel_bits == 4'd5) : 1'b0;
  assign b4.hwa_out  = cnt4;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cnt4 <= '0;
    else if (b4.start || b4.hwa_done) cnt4 <= '0;
    else if (b4.sel_bits != 4'd0)     cnt4 <= cnt4 + ((b4.taps[0] >= b4.R_y) ? 4'd1 : 4'd0);
  end

  // Trivial HWA for the N=8 instance: done exactly at the last counter value
  assign b8.hwa_done = (b8.sel_bits == 8'hFF);
  assign b8.hwa_out  = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic accept4(input logic [3:0] d);
    int n = 0;
    while (!b4.in_ready && n < 60) begin tick(); n++; end
    check("in_ready_wait4", b4.in_ready, 1);
    b4.in_valid = 1'b1;
    b4.in_data  = d;
    tick();
    b4.in_valid = 1'b0;
  endtask

  task automatic wait_y4();
    int n = 0;
    while (!b4.y_valid && n < 40) begin tick(); n++; end
    check("y_valid_wait4", b4.y_valid, 1);
  endtask

  task automatic send8(input logic [7:0] d);
    int n = 0;
    while (!b8.in_ready && n < 300) begin tick(); n++; end
    check("in_ready_wait8", b8.in_ready, 1);
    b8.in_valid = 1'b1;
    b8.in_data  = d;
    tick();
    b8.in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    done_mode = 0;
    seen = '0;
    // x^4+x^3+1 from seed 1, hand-stepped
    lfsr_exp = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
                 4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8};
    b4.in_valid = 1'b0; b4.in_data = '0; b4.y_ready = 1'b1;
    b8.in_valid = 1'b0; b8.in_data = '0; b8.y_ready = 1'b1;

    // ---- reset values
    rst_n = 1'b0;
    tick(); tick();
    check("rst_in_ready",  b4.in_ready, 1);
    check("rst_start",     b4.start, 0);
    check("rst_y_valid",   b4.y_valid, 0);
    check("rst_y_data",    b4.y_data, 0);
    check("rst_err",       b4.err, 0);
    check("rst_sel",       b4.sel_bits, 0);
    check("rst_r_y",       b4.R_y, 1);
    check("rst_taps",      32'(|b4.taps), 0);
    check("rst_r_y8",      b8.R_y, 1);
    rst_n = 1'b1;
    tick();

    // ---- single sample 0xF: latency, sel_bits sweep, LFSR sequence
    accept4(4'hF);                               // now in cycle 1
    check("c1_start",    b4.start, 1);
    check("c1_in_ready", b4.in_ready, 0);
    check("c1_sel",      b4.sel_bits, 0);
    check("c1_r_y",      b4.R_y, 1);
    for (int k = 1; k <= 15; k++) begin
      tick();                                    // cycle k+1
      check("run_sel",     b4.sel_bits, k);
      check("run_start",   b4.start, 0);
      check("run_y_valid", b4.y_valid, 0);
      check("run_r_y",     b4.R_y, lfsr_exp[k % 15]);
      seen[b4.R_y] = 1'b1;
    end
    check("lfsr_all_values", seen, 16'hFFFE);
    tick();                                      // cycle 17
    check("c17_y_valid",  b4.y_valid, 1);
    check("c17_y_data",   b4.y_data, 14);
    check("c17_err",      b4.err, 0);
    check("c17_in_ready", b4.in_ready, 0);
    check("c17_sel",      b4.sel_bits, 0);
    tick();                                      // cycle 18, idle again
    check("c18_y_valid",  b4.y_valid, 0);
    check("c18_in_ready", b4.in_ready, 1);
    check("c18_r_y",      b4.R_y, 2);
    tick(); tick(); tick();
    check("idle_r_y_hold", b4.R_y, 2);

    // ---- sample 0x0: comparator never true, count 0
    accept4(4'h0);
    wait_y4();
    check("zero_y_data", b4.y_data, 0);
    check("zero_err",    b4.err, 0);
    tick();

    // ---- backpressure
    b4.y_ready = 1'b0;
    accept4(4'hF);
    wait_y4();
    check("bp_y_data", b4.y_data, 14);
    b4.in_valid = 1'b1;
    b4.in_data  = 4'h5;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_y_valid",  b4.y_valid, 1);
      check("bp_y_data_hold", b4.y_data, 14);
      check("bp_in_ready", b4.in_ready, 0);
      check("bp_taps0",    b4.taps[0], 4'hF);
    end
    b4.y_ready = 1'b1;
    tick();                                      // consumed, back in IDLE
    check("bp_rel_y_valid",  b4.y_valid, 0);
    check("bp_rel_in_ready", b4.in_ready, 1);
    check("bp_rel_taps0",    b4.taps[0], 4'hF);
    tick();                                      // held in_valid accepted
    b4.in_valid = 1'b0;
    check("bp_acc_start", b4.start, 1);
    check("bp_acc_taps0", b4.taps[0], 4'h5);
    check("bp_acc_taps1", b4.taps[1], 4'hF);
    check("bp_acc_taps2", b4.taps[2], 4'h0);
    check("bp_acc_taps3", b4.taps[3], 4'hF);
    wait_y4();
    tick();

    // ---- done never arrives: capture at sel 15, err set
    done_mode = 1;
    accept4(4'hF);
    repeat (15) tick();                          // cycle 16
    check("nodone_sel15",   b4.sel_bits, 15);
    check("nodone_err_pre", b4.err, 0);
    tick();                                      // cycle 17
    check("nodone_y_valid", b4.y_valid, 1);
    check("nodone_y_data",  b4.y_data, 14);
    check("nodone_err",     b4.err, 1);
    tick();
    done_mode = 0;
    accept4(4'hF);
    wait_y4();
    check("sticky_y_data", b4.y_data, 14);
    check("sticky_err",    b4.err, 1);
    tick();
    rst_n = 1'b0;
    tick();
    check("err_cleared", b4.err, 0);
    rst_n = 1'b1;
    tick();

    // ---- early done at sel 5
    done_mode = 2;
    accept4(4'hF);
    repeat (5) tick();                           // cycle 6, sel 5
    check("early_sel5",    b4.sel_bits, 5);
    check("early_y_valid0", b4.y_valid, 0);
    check("early_err_pre", b4.err, 0);
    tick();
    check("early_y_valid", b4.y_valid, 1);
    check("early_y_data",  b4.y_data, 4);
    check("early_err",     b4.err, 1);
    check("early_sel0",    b4.sel_bits, 0);
    tick();
    done_mode = 0;

    // ---- asynchronous reset mid-RUN
    accept4(4'hF);
    repeat (5) tick();
    check("mid_in_run", b4.sel_bits, 5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", b4.in_ready, 1);
    check("arst_start",    b4.start, 0);
    check("arst_sel",      b4.sel_bits, 0);
    check("arst_r_y",      b4.R_y, 1);
    check("arst_y_valid",  b4.y_valid, 0);
    check("arst_y_data",   b4.y_data, 0);
    check("arst_err",      b4.err, 0);
    check("arst_taps",     32'(|b4.taps), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", b4.in_ready, 1);
    check("post_rst_r_y",      b4.R_y, 1);

    // ---- delay line on the N=8 instance: samples 1..40
    for (int v = 1; v <= 40; v++) send8(8'(v));
    check("dl_taps0",  b8.taps[0], 40);
    check("dl_taps1",  b8.taps[1], 39);
    check("dl_taps38", b8.taps[38], 2);
    check("dl_err",    b8.err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
